// File: rtl/input_map_pkg.sv
// Shared types and constants for the PS/2-to-button front end.
// Holds the key code type, common scancodes, the coin FSM states and the key table match rule.
package input_map_pkg;

  typedef logic [8:0] key_code_t;

  localparam key_code_t KEY_UP    = 9'h175;
  localparam key_code_t KEY_DOWN  = 9'h172;
  localparam key_code_t KEY_LEFT  = 9'h16B;
  localparam key_code_t KEY_RIGHT = 9'h174;
  localparam key_code_t KEY_LCTRL = 9'h014;
  localparam key_code_t KEY_SPACE = 9'h029;
  localparam key_code_t KEY_F1    = 9'h005;
  localparam key_code_t KEY_F2    = 9'h006;

  typedef enum logic [1:0] {
    COIN_IDLE,
    COIN_PULSE,
    COIN_GAP
  } coin_state_t;

  // An all-zero table entry means "unmapped", and a zero code is a filtered event.
  function automatic logic key_match(input key_code_t code, input key_code_t entry,
                                     input logic ext_any);
    if (code == '0 || entry == '0) return 1'b0;
    return ext_any ? (code[7:0] == entry[7:0]) : (code == entry);
  endfunction

endpackage

// File: rtl/ps2_button_mapper_coin_pulser.sv
// Coin pulse generator: fixed-width pulse, equal minimum gap, one request queued while busy.
module coin_pulser
  import input_map_pkg::*;
#(
  parameter logic [23:0] COIN_CYC = 24'd500000
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic req,
  output logic coin_pulse,
  output logic coin_busy
);

  localparam int CW = (COIN_CYC > 24'd1) ? $clog2(COIN_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(COIN_CYC - 24'd1);

  coin_state_t   state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          pending, pending_nxt;
  logic          cnt_done;

  assign cnt_done = (cnt == CNT_LAST);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nxt   = state;
    cnt_nxt     = cnt;
    pending_nxt = pending;
    unique case (state)
      COIN_IDLE: begin
        if (req) begin
          state_nxt = COIN_PULSE;
          cnt_nxt   = '0;
        end
      end
      COIN_PULSE: begin
        if (req) pending_nxt = 1'b1;
        if (cnt_done) begin
          state_nxt = COIN_GAP;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      COIN_GAP: begin
        if (cnt_done) begin
          cnt_nxt = '0;
          // A request arriving exactly as the gap ends is served like a queued one.
          if (pending || req) begin
            state_nxt   = COIN_PULSE;
            pending_nxt = 1'b0;
          end else begin
            state_nxt = COIN_IDLE;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
          if (req) pending_nxt = 1'b1;
        end
      end
      default: state_nxt = COIN_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    if (reset) begin
      state      <= COIN_IDLE;
      cnt        <= '0;
      pending    <= 1'b0;
      coin_pulse <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      pending    <= pending_nxt;
      coin_pulse <= (state_nxt == COIN_PULSE);
    end
  end

  assign coin_busy = (state != COIN_IDLE) || pending;

endmodule

// File: rtl/ps2_button_mapper.sv
// Keyboard/joystick-to-button front end: PS/2 key table decode, joystick merge,
// per-button autofire and a metered coin pulse from selected buttons.
module ps2_button_mapper
  import input_map_pkg::*;
#(
  parameter int                   NUM_BTN       = 8,
  parameter logic [9*NUM_BTN-1:0] KEYMAP        = {NUM_BTN{9'h000}},
  parameter logic [NUM_BTN-1:0]   KEY_EXTANY    = '0,
  parameter logic [NUM_BTN-1:0]   AUTOFIRE_MASK = '0,
  parameter logic [15:0]          AUTOFIRE_DIV  = 16'd50000,
  parameter logic [NUM_BTN-1:0]   COIN_MASK     = '0,
  parameter logic [23:0]          COIN_CYC      = 24'd500000
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic [64:0]        ps2_key,
  input  logic [NUM_BTN-1:0] joy_btn,
  input  logic               autofire_en,
  output logic [NUM_BTN-1:0] btn_held,
  output logic [NUM_BTN-1:0] btn_out,
  output logic               coin_pulse,
  output logic               coin_busy
);

  localparam int AW = (AUTOFIRE_DIV > 16'd1) ? $clog2(AUTOFIRE_DIV) : 1;
  localparam logic [AW-1:0] AF_LAST = AW'(AUTOFIRE_DIV - 16'd1);

  logic               pressed, ext, key_event, old_tog;
  key_code_t          code;
  logic [AW-1:0]      af_cnt;
  logic               af_phase;
  logic [NUM_BTN-1:0] af_gate, btn_out_q;
  logic               coin_req;

  // Break events carry F0 in [15:8], which pushes the E0 prefix up into [23:16].
  always_comb begin
    pressed = (ps2_key[15:8] != 8'hF0);
    ext     = pressed ? (ps2_key[15:8] == 8'hE0) : (ps2_key[23:16] == 8'hE0);
    code    = (|ps2_key[63:24]) ? key_code_t'(0) : {ext, ps2_key[7:0]};
  end

  assign key_event = ps2_key[64] ^ old_tog;

  always_ff @(posedge clk_sys) begin
    old_tog <= ps2_key[64];
    if (reset) begin
      btn_held <= '0;
    end else if (key_event) begin
      for (int i = 0; i < NUM_BTN; i++) begin
        if (key_match(code, KEYMAP[9*i +: 9], KEY_EXTANY[i])) btn_held[i] <= pressed;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      af_cnt   <= '0;
      af_phase <= 1'b1;
    end else if (af_cnt == AF_LAST) begin
      af_cnt   <= '0;
      af_phase <= ~af_phase;
    end else begin
      af_cnt <= af_cnt + 1'b1;
    end
  end

  assign af_gate = {NUM_BTN{af_phase}} | ~({NUM_BTN{autofire_en}} & AUTOFIRE_MASK);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      btn_out   <= '0;
      btn_out_q <= '0;
    end else begin
      btn_out   <= (btn_held | joy_btn) & af_gate;
      btn_out_q <= btn_out;
    end
  end

  assign coin_req = |(COIN_MASK & btn_out & ~btn_out_q);

  coin_pulser #(
    .COIN_CYC(COIN_CYC)
  ) u_coin (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .req       (coin_req),
    .coin_pulse(coin_pulse),
    .coin_busy (coin_busy)
  );

endmodule

// File: tb/tb_ps2_button_mapper.sv
// Self-checking bench for ps2_button_mapper: directed scenarios plus randomized traffic
// compared every cycle against a timeline-based reference model.
module tb_ps2_button_mapper;
  import input_map_pkg::*;

  localparam int          NB    = 4;
  localparam logic [35:0] KMAP  = {KEY_F1, KEY_SPACE, KEY_LCTRL, KEY_UP};
  localparam logic [3:0]  EXTA  = 4'b0001;
  localparam logic [3:0]  AFM   = 4'b0100;
  localparam logic [3:0]  COINM = 4'b1000;
  localparam int          DIV   = 4;
  localparam int          CYC   = 8;

  logic          clk_sys = 1'b0;
  logic          reset;
  logic [64:0]   ps2_key;
  logic [NB-1:0] joy_btn;
  logic          autofire_en;
  logic [NB-1:0] btn_held, btn_out;
  logic          coin_pulse, coin_busy;

  ps2_button_mapper #(
    .NUM_BTN      (NB),
    .KEYMAP       (KMAP),
    .KEY_EXTANY   (EXTA),
    .AUTOFIRE_MASK(AFM),
    .AUTOFIRE_DIV (16'(DIV)),
    .COIN_MASK    (COINM),
    .COIN_CYC     (24'(CYC))
  ) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .ps2_key    (ps2_key),
    .joy_btn    (joy_btn),
    .autofire_en(autofire_en),
    .btn_held   (btn_held),
    .btn_out    (btn_out),
    .coin_pulse (coin_pulse),
    .coin_busy  (coin_busy)
  );

  initial forever #5 clk_sys = ~clk_sys;

  int vectors     = 0;
  int miscompares = 0;
  int coin_hi_cnt = 0;

  // Reference model state: values visible during cycle m_cyc (cycles counted from reset).
  logic [NB-1:0] m_held, m_out, m_outq;
  logic          m_tog, m_pend, m_has, m_valid = 1'b0;
  int            m_cyc, m_s;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_step();
    logic        req, inwin, phase, pressed, ext;
    logic [8:0]  code, e;
    logic [NB-1:0] nout;
    int t;
    if (reset) begin
      m_held = '0; m_out = '0; m_outq = '0; m_tog = ps2_key[64];
      m_cyc = 0; m_has = 1'b0; m_pend = 1'b0; m_s = 0; m_valid = 1'b1;
    end else if (m_valid) begin
      t   = m_cyc;
      req = |(COINM & m_out & ~m_outq);
      inwin = m_has && (t >= m_s) && (t <= m_s + 2*CYC - 1);
      if (inwin && t == m_s + 2*CYC - 1) begin
        if (m_pend || req) begin m_s = t + 1; m_pend = 1'b0; end
      end else if (inwin) begin
        if (req) m_pend = 1'b1;
      end else if (req) begin
        m_s = t + 1; m_has = 1'b1;
      end
      phase = ((t / DIV) % 2) == 0;
      nout  = (m_held | joy_btn) & ~((autofire_en && !phase) ? AFM : 4'b0000);
      m_outq = m_out;
      m_out  = nout;
      if (ps2_key[64] != m_tog) begin
        pressed = ps2_key[15:8] != 8'hF0;
        ext  = pressed ? (ps2_key[15:8] == 8'hE0) : (ps2_key[23:16] == 8'hE0);
        code = (ps2_key[63:24] != 40'd0) ? 9'h000 : {ext, ps2_key[7:0]};
        for (int i = 0; i < NB; i++) begin
          e = KMAP[9*i +: 9];
          if (e != 9'h000 && code != 9'h000 &&
              (EXTA[i] ? (code[7:0] == e[7:0]) : (code == e)))
            m_held[i] = pressed;
        end
      end
      m_tog = ps2_key[64];
      m_cyc++;
    end
  endtask

  task automatic compare();
    logic ec, eb;
    ec = m_has && (m_cyc >= m_s) && (m_cyc < m_s + CYC);
    eb = (m_has && (m_cyc >= m_s) && (m_cyc < m_s + 2*CYC)) || m_pend;
    check("btn_held", 32'(btn_held), 32'(m_held));
    check("btn_out", 32'(btn_out), 32'(m_out));
    check("coin_pulse", 32'(coin_pulse), 32'(ec));
    check("coin_busy", 32'(coin_busy), 32'(eb));
    if (coin_pulse === 1'b1) coin_hi_cnt++;
  endtask

  task automatic send_key(input logic [39:0] upper, input logic [23:0] low);
    ps2_key = {~ps2_key[64], upper, low};
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic wait_coin(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk_sys);
      if (coin_pulse) ok = 1'b1;
    end
    if (!ok) check("coin_pulse_timeout", 32'd0, 32'd1);
  endtask

  task automatic rand_key();
    logic [7:0] codes [5];
    logic [7:0] c, pfx;
    logic [39:0] up;
    codes = '{8'h75, 8'h14, 8'h29, 8'h05, 8'h6B};
    c   = codes[$urandom_range(0, 4)];
    pfx = ($urandom_range(0, 1) == 1) ? 8'hE0 : 8'h00;
    up  = ($urandom_range(0, 7) == 0) ? {$urandom(), 8'h01} : 40'd0;
    if ($urandom_range(0, 1) == 1) send_key(up, {pfx, 8'hF0, c});
    else                           send_key(up, {8'h00, pfx, c});
  endtask

  initial begin
    bit ok;
    int base, toggles, first_hi, hi_cnt;
    logic prev;
    logic [20:0] cs, bs;

    reset = 1'b1; ps2_key = '0; joy_btn = '0; autofire_en = 1'b0;
    fork
      forever begin
        @(posedge clk_sys);
        model_step();
        #1;
        if (m_valid) compare();
      end
    join_none

    wait_cycles(3);
    check("reset_btn_out", 32'(btn_out), 32'd0);
    check("reset_btn_held", 32'(btn_held), 32'd0);
    check("reset_coin", 32'({coin_pulse, coin_busy}), 32'd0);
    reset = 1'b0;
    wait_cycles(2);

    // Make/break codes for UP, with and without the E0 prefix.
    send_key(40'd0, 24'h000075); wait_cycles(1);
    check("up_press", 32'(btn_held), 32'h1);
    send_key(40'd0, 24'h00F075); wait_cycles(1);
    check("up_release_noext", 32'(btn_held), 32'h0);
    send_key(40'd0, 24'h00E075); wait_cycles(1);
    check("up_press_ext", 32'(btn_held), 32'h1);
    send_key(40'd0, 24'hE0F075); wait_cycles(1);
    check("up_release_ext", 32'(btn_held), 32'h0);

    // Filtered event, then a toggle hidden under reset.
    send_key(40'h12, 24'h000029); wait_cycles(2);
    check("filtered", 32'(btn_held), 32'h0);
    reset = 1'b1;
    wait_cycles(1);
    ps2_key = {1'b1, 40'd0, 24'h000029};
    wait_cycles(2);
    reset = 1'b0;
    wait_cycles(3);
    check("no_event_after_reset", 32'(btn_held), 32'h0);

    // Autofire on SPACE.
    autofire_en = 1'b1;
    send_key(40'd0, 24'h000029);
    wait_cycles(4);
    check("space_held", 32'(btn_held), 32'h4);
    prev = btn_out[2]; toggles = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk_sys);
      if (btn_out[2] != prev) toggles++;
      prev = btn_out[2];
    end
    check("autofire_toggles", 32'(toggles), 32'd4);
    autofire_en = 1'b0;
    wait_cycles(1);
    check("autofire_off", 32'(btn_out[2]), 32'd1);
    joy_btn = 4'b0001;
    wait_cycles(1);
    check("joy_latency", 32'(btn_out[0]), 32'd1);
    joy_btn = 4'b0000;
    send_key(40'd0, 24'h00F029);
    wait_cycles(4);

    // Single coin pulse from F1.
    send_key(40'd0, 24'h000005);
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk_sys);
      if (btn_out[3]) ok = 1'b1;
    end
    check("f1_btn_out", 32'(ok), 32'd1);
    cs = '0; bs = '0;
    cs[0] = coin_pulse; bs[0] = coin_busy;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk_sys);
      cs[i] = coin_pulse; bs[i] = coin_busy;
    end
    first_hi = -1; hi_cnt = 0;
    for (int i = 0; i <= 20; i++) begin
      if (cs[i]) begin
        hi_cnt++;
        if (first_hi < 0) first_hi = i;
      end
    end
    check("coin_first_hi", 32'(first_hi), 32'd1);
    check("coin_width", 32'(hi_cnt), 32'd8);
    check("coin_busy_gap_end", 32'(bs[16]), 32'd1);
    check("coin_busy_idle", 32'(bs[17]), 32'd0);
    send_key(40'd0, 24'h00F005);
    wait_cycles(6);

    // Two re-presses while busy: one queued pulse, the second dropped.
    base = coin_hi_cnt;
    send_key(40'd0, 24'h000005);
    wait_coin(ok);
    for (int k = 0; k < 2; k++) begin
      send_key(40'd0, 24'h00F005); wait_cycles(2);
      send_key(40'd0, 24'h000005); wait_cycles(2);
    end
    wait_cycles(60);
    check("queued_pulse_total", 32'(coin_hi_cnt - base), 32'd16);
    send_key(40'd0, 24'h00F005);
    wait_cycles(6);

    // Reset during the third pulse cycle.
    send_key(40'd0, 24'h000005);
    wait_coin(ok);
    wait_cycles(2);
    reset = 1'b1;
    wait_cycles(1);
    check("rst_mid_pulse", 32'({coin_pulse, coin_busy}), 32'd0);
    check("rst_mid_btn_out", 32'(btn_out), 32'd0);
    reset = 1'b0;
    base = coin_hi_cnt;
    wait_cycles(40);
    check("no_pulse_after_reset", 32'(coin_hi_cnt - base), 32'd0);

    // Randomized traffic.
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk_sys);
      reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 99) < 20) rand_key();
      if ($urandom_range(0, 99) < 8)  joy_btn = 4'($urandom());
      if ($urandom_range(0, 99) < 2)  autofire_en = ~autofire_en;
    end
    reset = 1'b0;
    wait_cycles(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
